add_serial: RTL and testbench



---
 rtl/add_serial.sv | 149 ++++++++++++++
 tb/tb_add_serial.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial.sv
// add_serial: bit-serial two's-complement adder.
// Accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake,
// resolves one bit per clock through a single full-adder cell, and returns the
// sum and carry-out over a second valid/ready handshake.
// Optional feature macro: ADD_SERIAL_OVF_EN adds the signed-overflow output ovf.
module add_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef ADD_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=2.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic             c_r;      // running carry; after the MSB it is the carry-out
  logic [CW-1:0]    cnt_r;
  logic             sum_bit_s;
  logic             carry_s;
  logic             accept_s;
  logic             last_s;

  // Single full-adder cell fed by the operand LSBs and the carry flop.
  always_comb begin
    sum_bit_s = a_r[0] ^ b_r[0] ^ c_r;
    carry_s   = (a_r[0] & b_r[0]) | (a_r[0] & c_r) | (b_r[0] & c_r);
  end

  assign accept_s = in_valid && in_ready;
  assign last_s   = (state_r == RUN) && (cnt_r == LAST);

  // State register; reset wins over both handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and handshake outputs decoded from the registered state.
  always_comb begin
    state_s   = state_r;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath: load on acceptance, shift one bit per RUN cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      c_r   <= 1'b0;
      cnt_r <= '0;
    end else if (accept_s) begin
      a_r   <= a;
      b_r   <= b;
      c_r   <= cin;
      cnt_r <= '0;
    end else if (state_r == RUN) begin
      a_r   <= a_r >> 1;
      b_r   <= b_r >> 1;
      s_r   <= {sum_bit_s, s_r[WIDTH-1:1]};
      c_r   <= carry_s;
      cnt_r <= cnt_r + CW'(1);
    end else begin
      a_r   <= a_r;
      b_r   <= b_r;
      s_r   <= s_r;
      c_r   <= c_r;
      cnt_r <= cnt_r;
    end
  end

  assign s    = s_r;
  assign cout = c_r;

`ifdef ADD_SERIAL_OVF_EN
  logic ovf_r;

  // Overflow: carry into the MSB (c_r) XOR carry out of the MSB, taken on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (last_s) begin
      ovf_r <= c_r ^ carry_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_add_serial.sv
// Self-checking bench for add_serial (WIDTH=4 and WIDTH=8 instances).
module tb_add_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
  logic [3:0] a4, b4, s4;
  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, s8;
  logic       ovf4, ovf8;

  int tests  = 0;
  int failed = 0;

  add_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .s(s4), .cout(cout4)
`ifdef ADD_SERIAL_OVF_EN
    , .ovf(ovf4)
`endif
  );

  add_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .cout(cout8)
`ifdef ADD_SERIAL_OVF_EN
    , .ovf(ovf8)
`endif
  );

`ifndef ADD_SERIAL_OVF_EN
  assign ovf4 = 1'b0;
  assign ovf8 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum in w+1 bits -> {cout, s}.
  function automatic int ref_sum(input int w, input int av, input int bv, input int c);
    return (av + bv + c) % (1 << (w + 1));
  endfunction

  // Reference: signed result outside the w-bit two's-complement range.
  function automatic logic ref_ovf(input int w, input int av, input int bv, input int c);
    int sa, sb, sum;
    sa  = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb  = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    sum = sa + sb + c;
    return (sum > (1 << (w - 1)) - 1) || (sum < -(1 << (w - 1)));
  endfunction

  // One WIDTH=4 operation with out_ready held high.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc, input string tag);
    int lat;
    int exp;
    exp = ref_sum(4, int'(ta), int'(tb_), int'(tc));
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1; a4 = ta; b4 = tb_; cin4 = tc; out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_s"}, 32'(s4), 32'(exp % 16));
    chk({tag, "_cout"}, 32'(cout4), 32'(exp / 16));
`ifdef ADD_SERIAL_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf4), 32'(ref_ovf(4, int'(ta), int'(tb_), int'(tc))));
`endif
    @(negedge clk);
    chk({tag, "_out_valid_after"}, 32'(out_valid4), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(in_ready4), 32'd1);
  endtask

  initial begin : main
    int lat, seen, idx, got, cyc, exp;
    logic acc, hs;
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic       pc [3];
    int expq [$];
    int acc_t [$];

    rst = 1'b1;
    in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0; out_ready8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_s", 32'(s4), 32'd0);
    chk("rst_cout", 32'(cout4), 32'd0);
    chk("rst_in_ready", 32'(in_ready4), 32'd0);
    chk("rst_ovf", 32'(ovf4), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", 32'(in_ready4), 32'd1);

    // Directed cases.
    op4(4'd7, 4'd8, 1'b0, "basic");
    op4(4'hF, 4'd0, 1'b1, "wrap1");
    op4(4'hF, 4'hF, 1'b1, "wrap2");
    op4(4'd7, 4'd1, 1'b0, "ovf_pos");
    op4(4'd8, 4'd8, 1'b0, "ovf_neg");
    op4(4'hF, 4'd1, 1'b0, "no_ovf");

    // Random cases.
    for (int i = 0; i < 8; i++) begin
      op4(4'($urandom), 4'($urandom), 1'($urandom), "rand4");
    end

    // Backpressure: hold DONE for 10 cycles, try to inject new operands.
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'd5; b4 = 4'd6; cin4 = 1'b1; out_ready4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid4), 32'd1);
      chk("bp_s", 32'(s4), 32'hC);
      chk("bp_cout", 32'(cout4), 32'd0);
      chk("bp_in_ready", 32'(in_ready4), 32'd0);
      if (i == 3) begin
        in_valid4 = 1'b1; a4 = 4'd1; b4 = 4'd1; cin4 = 1'b0;
      end else begin
        in_valid4 = 1'b0;
      end
    end
    out_ready4 = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid4), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready4), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid4) seen++;
    end
    chk("bp_no_ghost_result", 32'(seen), 32'd0);

    // Reset mid-RUN: rst sampled on the second edge after acceptance.
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'd9; b4 = 4'd5; cin4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid4), 32'd0);
    chk("midrst_s", 32'(s4), 32'd0);
    chk("midrst_cout", 32'(cout4), 32'd0);
    chk("midrst_ovf", 32'(ovf4), 32'd0);
    chk("midrst_in_ready", 32'(in_ready4), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_release_in_ready", 32'(in_ready4), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid4) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    op4(4'd3, 4'd4, 1'b0, "post_rst");

    // Back-to-back on WIDTH=8 with in_valid held high.
    for (int i = 0; i < 3; i++) begin
      pa[i] = 8'($urandom); pb[i] = 8'($urandom); pc[i] = 1'($urandom);
    end
    pa[0] = 8'hFF; pb[0] = 8'h01; pc[0] = 1'b0;
    idx = 0; got = 0; cyc = 0;
    @(negedge clk);
    in_valid8 = 1'b1; a8 = pa[0]; b8 = pb[0]; cin8 = pc[0]; out_ready8 = 1'b1;
    while (got < 3 && cyc < 200) begin
      acc = in_valid8 && in_ready8;
      hs  = out_valid8 && out_ready8;
      if (acc) begin
        exp = ref_sum(8, int'(a8), int'(b8), int'(cin8));
        if (ref_ovf(8, int'(a8), int'(b8), int'(cin8))) exp = exp + 512;
        expq.push_back(exp);
        acc_t.push_back(cyc);
      end
      if (hs) begin
        if (expq.size() == 0) begin
          chk("b2b_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp = expq.pop_front();
          chk("b2b_sum", 32'({cout8, s8}), 32'(exp % 512));
`ifdef ADD_SERIAL_OVF_EN
          chk("b2b_ovf", 32'(ovf8), 32'(exp / 512));
`endif
        end
        got++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          a8 = pa[idx]; b8 = pb[idx]; cin8 = pc[idx];
        end else begin
          in_valid8 = 1'b0;
        end
      end
    end
    chk("b2b_result_count", 32'(got), 32'd3);
    if (acc_t.size() == 3) begin
      chk("b2b_spacing1", 32'(acc_t[1] - acc_t[0]), 32'd10);
      chk("b2b_spacing2", 32'(acc_t[2] - acc_t[1]), 32'd10);
    end else begin
      chk("b2b_accept_count", 32'(acc_t.size()), 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
